// File: rtl/usb_stream_pkg.sv
// Shared definitions for the USB data stream.
// Holds the tag/abort marker words, the legacy stream words used by the
// S-curve readout, and the write-arbiter state encoding.
package usb_stream_pkg;

    localparam logic [7:0]  TAG_BYTE        = 8'h54;
    localparam logic [15:0] ABORT_WORD      = 16'hFFAB;
    localparam logic [15:0] SCURVE_HDR_WORD = 16'h5343;
    localparam logic [15:0] STREAM_END_WORD = 16'hFF45;

    typedef enum logic [1:0] {
        IDLE,
        TAG,
        XFER,
        ABORT
    } arb_state_t;

    // Tag word announcing which source owns the packet that follows.
    function automatic logic [15:0] tag_word(input logic [3:0] id);
        return {TAG_BYTE, 4'h0, id};
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin priority picker (purely combinational).
// The first requesting source strictly after ptr wins, wrapping around, so
// the source at ptr itself is considered last.
// Ports:
//   req    in   NUM_REQ  request vector
//   ptr    in   4        index of the previous winner
//   grant  out  NUM_REQ  one-hot winner (all zero when no request)
//   idx    out  4        index of the winner (0 when no request)
module rr_priority_picker #(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [3:0]         ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [3:0]         idx
);

    logic found;

    // Two passes: first the sources above the pointer, then the wrap-around
    // part from 0 up to and including the pointer.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (4'(i) > ptr)) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                idx      = 4'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (4'(i) <= ptr)) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                idx      = 4'(i);
            end
        end
    end

endmodule

// File: rtl/usb_fifo_write_arbiter.sv
// Packet-atomic round-robin arbiter sharing the USB data FIFO write port
// between NUM_REQ producers. Optionally prepends a source tag word to each
// packet, and a stall watchdog releases the port from a hung source by
// writing an abort marker.
// Ports:
//   Clk, reset_n           clock, synchronous active-low reset
//   req_valid/data/last    per-source word stream (source i on data[16*i+:16])
//   req_ready              per-source accept, only the owner can be ready
//   usb_data_fifo_full     prog-full from the FIFO (>=2 slots still free)
//   usb_data_fifo_wr_en    write strobe, one per word
//   usb_data_fifo_wr_din   write data
//   grant_id, busy         current owner / packet in progress
//   abort_pulse            one-cycle pulse with the abort marker write
//
// state | meaning
// IDLE  | port free; arbitrate among valid sources
// TAG   | owner granted; write the tag word when FIFO not full
// XFER  | forward owner words with one cycle of registered latency
// ABORT | watchdog fired; write the abort marker when FIFO not full
module usb_fifo_write_arbiter
    import usb_stream_pkg::*;
#(
    parameter int NUM_REQ   = 3,
    parameter int TAG_EN    = 1,
    parameter int TIMEOUT   = 4095,
    parameter int TIMEOUT_W = 12
) (
    input  logic                   Clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [16*NUM_REQ-1:0]  req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic                   usb_data_fifo_full,
    output logic                   usb_data_fifo_wr_en,
    output logic [15:0]            usb_data_fifo_wr_din,
    output logic [3:0]             grant_id,
    output logic                   busy,
    output logic                   abort_pulse
);

    localparam logic [TIMEOUT_W-1:0] WD_LOAD = TIMEOUT_W'(TIMEOUT);

    arb_state_t           state;
    logic [3:0]           rr_ptr;
    logic [TIMEOUT_W-1:0] wd_cnt;

    logic [NUM_REQ-1:0]   pick_grant;
    logic [3:0]           pick_idx;
    logic                 pick_any;

    logic                 own_valid;
    logic                 own_last;
    logic [15:0]          own_data;
    logic                 accept;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    assign pick_any = |pick_grant;

    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == 4'(i)) begin
                own_valid = req_valid[i];
                own_last  = req_last[i];
                own_data  = req_data[16*i +: 16];
            end
        end
    end

    // Ready follows full combinationally; the word already registered for
    // writing is absorbed by the prog-full margin.
    always_comb begin
        req_ready = '0;
        if (state == XFER && !usb_data_fifo_full) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_id == 4'(i)) begin
                    req_ready[i] = 1'b1;
                end
            end
        end
    end

    assign accept = (state == XFER) && !usb_data_fifo_full && own_valid;

    always_ff @(posedge Clk) begin
        if (!reset_n) begin
            state                <= IDLE;
            rr_ptr               <= 4'(NUM_REQ - 1);
            wd_cnt               <= WD_LOAD;
            grant_id             <= '0;
            busy                 <= 1'b0;
            usb_data_fifo_wr_en  <= 1'b0;
            usb_data_fifo_wr_din <= '0;
            abort_pulse          <= 1'b0;
        end else begin
            usb_data_fifo_wr_en <= 1'b0;
            abort_pulse         <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant_id <= pick_idx;
                        rr_ptr   <= pick_idx;
                        busy     <= 1'b1;
                        wd_cnt   <= WD_LOAD;
                        state    <= (TAG_EN != 0) ? TAG : XFER;
                    end
                end
                TAG: begin
                    if (!usb_data_fifo_full) begin
                        usb_data_fifo_wr_en  <= 1'b1;
                        usb_data_fifo_wr_din <= tag_word(grant_id);
                        state                <= XFER;
                    end
                end
                XFER: begin
                    if (accept) begin
                        usb_data_fifo_wr_en  <= 1'b1;
                        usb_data_fifo_wr_din <= own_data;
                        wd_cnt               <= WD_LOAD;
                        if (own_last) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else if (!own_valid && !usb_data_fifo_full) begin
                        // Down-counter: terminal count reached on the
                        // TIMEOUT-th silent cycle; full-stall cycles are
                        // not the source's fault and are not counted.
                        if (wd_cnt <= TIMEOUT_W'(1)) begin
                            state <= ABORT;
                        end else begin
                            wd_cnt <= wd_cnt - 1'b1;
                        end
                    end
                end
                ABORT: begin
                    if (!usb_data_fifo_full) begin
                        usb_data_fifo_wr_en  <= 1'b1;
                        usb_data_fifo_wr_din <= ABORT_WORD;
                        abort_pulse          <= 1'b1;
                        busy                 <= 1'b0;
                        state                <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_fifo_write_arbiter.sv
// Bench for usb_fifo_write_arbiter: one tagged instance with a short
// watchdog and one untagged instance, driven from per-source packet queues
// and checked against a packet-level model of the output stream.
module tb_usb_fifo_write_arbiter;

    localparam int N   = 3;
    localparam int TMO = 8;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic              reset_n;
    logic [N-1:0]      req_valid, req_last, req_ready;
    logic [16*N-1:0]   req_data;
    logic              full, wr_en, busy, abort_pulse;
    logic [15:0]       din;
    logic [3:0]        grant_id;

    logic [N-1:0]      b_valid, b_last, b_ready;
    logic [16*N-1:0]   b_data;
    logic              b_full, b_wr_en, b_busy, b_abort;
    logic [15:0]       b_din;
    logic [3:0]        b_grant;

    usb_fifo_write_arbiter #(.NUM_REQ(N), .TAG_EN(1), .TIMEOUT(TMO), .TIMEOUT_W(4)) dut_a (
        .Clk(Clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .usb_data_fifo_full(full),
        .usb_data_fifo_wr_en(wr_en), .usb_data_fifo_wr_din(din), .grant_id(grant_id),
        .busy(busy), .abort_pulse(abort_pulse));

    usb_fifo_write_arbiter #(.NUM_REQ(N), .TAG_EN(0), .TIMEOUT(4095), .TIMEOUT_W(12)) dut_b (
        .Clk(Clk), .reset_n(reset_n), .req_valid(b_valid), .req_data(b_data),
        .req_last(b_last), .req_ready(b_ready), .usb_data_fifo_full(b_full),
        .usb_data_fifo_wr_en(b_wr_en), .usb_data_fifo_wr_din(b_din), .grant_id(b_grant),
        .busy(b_busy), .abort_pulse(b_abort));

    int n_chk = 0;
    int n_fail = 0;

    // {last, word}: prod_q is what each producer still has to hand over,
    // exp_q is what the output stream still owes for that source.
    logic [16:0] prod_q [N][$];
    logic [16:0] exp_q  [N][$];

    logic [N-1:0] hold, hold_after_pop, hs, prev_valid;
    bit           gap_en, rand_full, full_force, chk_en;
    bit           in_pkt, prev_busy;
    int           cur_src, exp_src, last_win;
    logic [15:0]  wr_log[$];
    int           wr_cyc[$];
    int           cycle, abort_cnt, wr_cnt;
    int           b_wr_cnt, b_wr_cyc;
    logic [15:0]  b_wr_din;
    logic         b_busy_wr;
    logic [N-1:0] b_hs;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    function automatic int next_winner(input logic [N-1:0] v, input int last);
        int c;
        for (int k = 1; k <= N; k++) begin
            c = (last + k) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic int pending();
        int s;
        s = 0;
        for (int i = 0; i < N; i++) s += prod_q[i].size();
        return s;
    endfunction

    task automatic add_pkt(input int src, input int len, input logic [15:0] base);
        logic [16:0] w;
        for (int k = 0; k < len; k++) begin
            w = {(k == len - 1), base + 16'(k)};
            prod_q[src].push_back(w);
            exp_q[src].push_back(w);
        end
    endtask

    task automatic monitor();
        logic [16:0]  e;
        logic [N-1:0] mask;
        if (busy && !prev_busy) begin
            exp_src = next_winner(prev_valid, last_win);
            check_eq("arb_grant", grant_id, exp_src);
            last_win = exp_src;
        end
        mask = busy ? (N'(1) << exp_src) : '0;
        check_eq("ready_owner_only", req_ready & ~mask, 0);
        if (full) check_eq("ready_when_full", req_ready, 0);
        check_eq("abort_pulse", abort_pulse, wr_en && in_pkt && (din == 16'hFFAB));
        if (wr_en) begin
            wr_cnt++;
            wr_log.push_back(din);
            wr_cyc.push_back(cycle);
            if (!in_pkt) begin
                check_eq("tag_word", din, {8'h54, 4'h0, 4'(exp_src)});
                in_pkt  = 1'b1;
                cur_src = exp_src;
            end else if (din == 16'hFFAB) begin
                abort_cnt++;
                check_eq("busy_at_abort", busy, 0);
                in_pkt = 1'b0;
            end else if (exp_q[cur_src].size() == 0) begin
                check_eq("extra_word", 32'(exp_q[cur_src].size()), 1);
            end else begin
                e = exp_q[cur_src].pop_front();
                check_eq("data_word", din, e[15:0]);
                if (e[16]) begin
                    check_eq("busy_at_last", busy, 0);
                    in_pkt = 1'b0;
                end
            end
        end
        prev_busy = busy;
    endtask

    task automatic drive();
        bit show;
        full = full_force || (rand_full && ($urandom_range(0, 4) == 0));
        for (int i = 0; i < N; i++) begin
            show = (prod_q[i].size() > 0) && !hold[i] && !(gap_en && ($urandom_range(0, 3) == 0));
            req_valid[i]        = show;
            req_data[16*i +: 16] = show ? prod_q[i][0][15:0] : 16'h0;
            req_last[i]         = show ? prod_q[i][0][16] : 1'b0;
        end
    endtask

    task automatic step();
        @(negedge Clk);
        if (chk_en) monitor();
        hs         = req_valid & req_ready;
        prev_valid = req_valid;
        if (b_wr_en) begin
            b_wr_cnt++;
            b_wr_cyc  = cycle;
            b_wr_din  = b_din;
            b_busy_wr = b_busy;
        end
        b_hs = b_valid & b_ready;
        @(posedge Clk);
        #1;
        cycle++;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                void'(prod_q[i].pop_front());
                if (hold_after_pop[i]) begin
                    hold[i]           = 1'b1;
                    hold_after_pop[i] = 1'b0;
                end
            end
        end
        b_valid = b_valid & ~b_hs;
        drive();
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((pending() > 0 || busy) && k < budget) begin
            step();
            k++;
        end
        step();
        step();
        if (k >= budget) check_eq("drain_timeout", k, 0);
    endtask

    task automatic clear_log();
        wr_log.delete();
        wr_cyc.delete();
    endtask

    task automatic reset_dut();
        reset_n   = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        full      = 1'b0;
        b_valid   = '0;
        b_last    = '0;
        b_data    = '0;
        for (int i = 0; i < N; i++) begin
            prod_q[i].delete();
            exp_q[i].delete();
        end
        hold = '0;
        hold_after_pop = '0;
        full_force = 1'b0;
        @(posedge Clk);
        #1;
        cycle++;
        check_eq("rst_wr_en", wr_en, 0);
        check_eq("rst_din", din, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_grant", grant_id, 0);
        check_eq("rst_abort", abort_pulse, 0);
        check_eq("rst_ready", req_ready, 0);
        check_eq("rst_b_wr_en", b_wr_en, 0);
        check_eq("rst_b_busy", b_busy, 0);
        reset_n    = 1'b1;
        in_pkt     = 1'b0;
        prev_busy  = 1'b0;
        prev_valid = '0;
        hs         = '0;
        last_win   = N - 1;
        exp_src    = N - 1;
        abort_cnt  = 0;
        clear_log();
    endtask

    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [15:0] exp_list[$];
        int          k;
        int          c0;
        int          w0;

        reset_n = 1'b0;
        req_valid = '0; req_last = '0; req_data = '0; full = 1'b0;
        b_valid = '0; b_last = '0; b_data = '0; b_full = 1'b0;
        hold = '0; hold_after_pop = '0; hs = '0; b_hs = '0; prev_valid = '0;
        gap_en = 0; rand_full = 0; full_force = 0; chk_en = 0;
        cycle = 0; wr_cnt = 0; b_wr_cnt = 0; b_wr_cyc = 0; b_wr_din = '0; b_busy_wr = 1'b0;
        cur_src = 0;
        repeat (3) @(posedge Clk);
        #1;
        reset_dut();
        chk_en = 1;

        // Single packet from source 1.
        add_pkt(1, 3, 16'h2001);
        drain(200);
        exp_list = '{16'h5401, 16'h2001, 16'h2002, 16'h2003};
        check_eq("t1_len", wr_log.size(), exp_list.size());
        for (int i = 0; i < exp_list.size(); i++) check_eq("t1_word", wr_log[i], exp_list[i]);

        // Sources 0 and 2 together right after reset.
        reset_dut();
        add_pkt(0, 2, 16'h1101);
        add_pkt(2, 2, 16'h3101);
        drain(200);
        exp_list = '{16'h5400, 16'h1101, 16'h1102, 16'h5402, 16'h3101, 16'h3102};
        check_eq("t2_len", wr_log.size(), exp_list.size());
        for (int i = 0; i < exp_list.size(); i++) check_eq("t2_word", wr_log[i], exp_list[i]);

        // Ten-cycle full stall in the middle of a packet.
        clear_log();
        add_pkt(1, 6, 16'h2101);
        k = 0;
        while (wr_log.size() < 3 && k < 50) begin
            step();
            k++;
        end
        full_force = 1'b1;
        full = 1'b1;
        step();
        w0 = wr_cnt;
        repeat (9) step();
        check_eq("t3_stall_writes", wr_cnt - w0, 0);
        full_force = 1'b0;
        drain(200);
        check_eq("t3_len", wr_log.size(), 7);
        check_eq("t3_no_abort", abort_cnt, 0);

        // Source 0 goes silent mid-packet while source 1 waits.
        reset_dut();
        add_pkt(0, 2, 16'h1201);
        add_pkt(1, 1, 16'h2201);
        hold_after_pop[0] = 1'b1;
        repeat (30) step();
        check_eq("t4_len_a", wr_log.size(), 5);
        exp_list = '{16'h5400, 16'h1201, 16'hFFAB, 16'h5401, 16'h2201};
        for (int i = 0; i < exp_list.size(); i++) check_eq("t4_word", wr_log[i], exp_list[i]);
        check_eq("t4_abort_gap", wr_cyc[2] - wr_cyc[1], TMO + 1);
        check_eq("t4_abort_cnt", abort_cnt, 1);
        hold[0] = 1'b0;
        drain(200);
        check_eq("t4_len_b", wr_log.size(), 7);
        check_eq("t4_resume_tag", wr_log[5], 16'h5400);
        check_eq("t4_resume_word", wr_log[6], 16'h1202);

        // Reset in the middle of a transfer.
        reset_dut();
        add_pkt(2, 8, 16'h3301);
        k = 0;
        while (wr_log.size() < 4 && k < 60) begin
            step();
            k++;
        end
        reset_dut();
        add_pkt(0, 1, 16'h1301);
        drain(200);
        check_eq("t5_len", wr_log.size(), 2);
        check_eq("t5_tag", wr_log[0], 16'h5400);
        check_eq("t5_word", wr_log[1], 16'h1301);

        // Untagged instance: single-word packet from source 2.
        b_data[32 +: 16] = 16'h1234;
        b_last  = 3'b100;
        b_valid = 3'b100;
        c0 = cycle;
        b_wr_cnt = 0;
        repeat (8) step();
        check_eq("t6_wr_count", b_wr_cnt, 1);
        check_eq("t6_latency", b_wr_cyc - c0, 2);
        check_eq("t6_data", b_wr_din, 16'h1234);
        check_eq("t6_busy_at_last", b_busy_wr, 0);

        // Random traffic with gaps and random full.
        reset_dut();
        gap_en = 1;
        rand_full = 1;
        for (int r = 0; r < 2; r++) begin
            for (int s = 0; s < N; s++) begin
                for (int p = 0; p < 4; p++) begin
                    add_pkt(s, $urandom_range(1, 5),
                            16'((s + 1) << 12) | 16'(((r * 4 + p) & 15) << 4) | 16'h1);
                end
            end
            repeat ($urandom_range(5, 40)) step();
        end
        drain(4000);
        check_eq("rand_left_prod", pending(), 0);
        k = 0;
        for (int i = 0; i < N; i++) k += exp_q[i].size();
        check_eq("rand_left_expected", k, 0);
        check_eq("rand_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
